// File: rtl/pe_config_sequencer.sv
// Loads one instruction word per PE through a one-hot strobe, then drives operand_en for iter_count cycles.
// Latency: a word reaches instr_en/instr_data one cycle after its handshake; done follows the last operand_en.
// Backpressure: cfg_ready is high only while loading; stalls of any length hold the sequence in place.
module pe_config_sequencer #(
    parameter int NUM_PE = 4,
    parameter int ITER_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ITER_W-1:0]         iter_count,
    input  logic                      cfg_valid,
    input  logic [31:0]               cfg_word,
    output logic                      cfg_ready,
    output logic [NUM_PE-1:0]         instr_en,
    output logic [31:0]               instr_data,
    output logic                      operand_en,
    output logic                      pe_clear,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NUM_PE)-1:0] pe_idx
);

    localparam int IDX_W = $clog2(NUM_PE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ITER_W-1:0]  iter_q, iter_q_nxt;
    logic [ITER_W-1:0]  iter_cnt, iter_cnt_nxt;
    logic [NUM_PE-1:0]  instr_en_nxt;
    logic [31:0]        instr_data_nxt;
    logic               operand_en_nxt;
    logic               pe_clear_nxt;
    logic               done_nxt;
    logic [IDX_W-1:0]   pe_idx_nxt;
    logic               cfg_hs;

    assign cfg_ready = (state == S_LOAD) && !abort;
    assign cfg_hs    = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt      = state;
        iter_q_nxt     = iter_q;
        iter_cnt_nxt   = iter_cnt;
        instr_en_nxt   = '0;
        instr_data_nxt = instr_data;
        operand_en_nxt = 1'b0;
        pe_clear_nxt   = 1'b0;
        done_nxt       = 1'b0;
        pe_idx_nxt     = pe_idx;

        if (abort) begin
            state_nxt  = S_IDLE;
            pe_idx_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt    = S_CLEAR;
                        pe_clear_nxt = 1'b1;
                        pe_idx_nxt   = '0;
                        iter_q_nxt   = iter_count;
                        iter_cnt_nxt = '0;
                    end
                end
                S_CLEAR: state_nxt = S_LOAD;
                S_LOAD: begin
                    if (cfg_hs) begin
                        instr_en_nxt[pe_idx] = 1'b1;
                        instr_data_nxt       = cfg_word;
                        if (pe_idx == IDX_W'(NUM_PE - 1)) begin
                            pe_idx_nxt = '0;
                            state_nxt  = S_EXEC;
                        end else begin
                            pe_idx_nxt = pe_idx + 1'b1;
                        end
                    end
                end
                // First EXEC cycle carries the final instruction write, so operand_en
                // starts one cycle later and the two strobes never overlap.
                S_EXEC: begin
                    if (iter_cnt == iter_q) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        operand_en_nxt = 1'b1;
                        iter_cnt_nxt   = iter_cnt + 1'b1;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            iter_q     <= '0;
            iter_cnt   <= '0;
            instr_en   <= '0;
            instr_data <= '0;
            operand_en <= 1'b0;
            pe_clear   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pe_idx     <= '0;
        end else begin
            state      <= state_nxt;
            iter_q     <= iter_q_nxt;
            iter_cnt   <= iter_cnt_nxt;
            instr_en   <= instr_en_nxt;
            instr_data <= instr_data_nxt;
            operand_en <= operand_en_nxt;
            pe_clear   <= pe_clear_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != S_IDLE);
            pe_idx     <= pe_idx_nxt;
        end
    end

endmodule

// File: tb/tb_pe_config_sequencer.sv
// Bench for pe_config_sequencer: randomized sequences checked against a timeline model of one config+run pass.
module tb_pe_config_sequencer;

    localparam int NUM_PE = 4;
    localparam int ITER_W = 16;
    localparam int PIDX_W = $clog2(NUM_PE);

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] iter_count;
    logic              cfg_valid;
    logic [31:0]       cfg_word;
    logic              cfg_ready;
    logic [NUM_PE-1:0] instr_en;
    logic [31:0]       instr_data;
    logic              operand_en;
    logic              pe_clear;
    logic              busy;
    logic              done;
    logic [PIDX_W-1:0] pe_idx;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_data;

    pe_config_sequencer #(.NUM_PE(NUM_PE), .ITER_W(ITER_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .iter_count (iter_count),
        .cfg_valid  (cfg_valid),
        .cfg_word   (cfg_word),
        .cfg_ready  (cfg_ready),
        .instr_en   (instr_en),
        .instr_data (instr_data),
        .operand_en (operand_en),
        .pe_clear   (pe_clear),
        .busy       (busy),
        .done       (done),
        .pe_idx     (pe_idx)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        cfg_word = 32'hdead_beef; iter_count = 16'd7;
        repeat (3) step();
        reset = 1'b0;
        exp_data = 32'h0;
        tests++; if (instr_en !== '0)    begin fails++; $display("FAIL reset instr_en got %b exp 0", instr_en); end
        tests++; if (instr_data !== '0)  begin fails++; $display("FAIL reset instr_data got %h exp 0", instr_data); end
        tests++; if (operand_en !== 0)   begin fails++; $display("FAIL reset operand_en got %b exp 0", operand_en); end
        tests++; if (pe_clear !== 0)     begin fails++; $display("FAIL reset pe_clear got %b exp 0", pe_clear); end
        tests++; if (busy !== 0)         begin fails++; $display("FAIL reset busy got %b exp 0", busy); end
        tests++; if (done !== 0)         begin fails++; $display("FAIL reset done got %b exp 0", done); end
        tests++; if (pe_idx !== '0)      begin fails++; $display("FAIL reset pe_idx got %0d exp 0", pe_idx); end
        tests++; if (cfg_ready !== 0)    begin fails++; $display("FAIL reset cfg_ready got %b exp 0", cfg_ready); end
        step();
        tests++; if (busy !== 0)         begin fails++; $display("FAIL reset idle_busy got %b exp 0", busy); end
    endtask

    // vmode: 0 = cfg_valid always high, 1 = toggles each cycle, 2 = random.
    task automatic test_sequence(input string name, input int iter, input int vmode, input bit hold_start);
        int                t;
        int                nh;
        int                last_hs;
        int                wr_idx;
        bit                pend;
        bit                v;
        bit                rdy;
        bit                op;
        bit                dn;
        bit                bz;
        logic [31:0]       w;
        logic [31:0]       wr_word;
        logic [NUM_PE-1:0] exp_en;
        logic [PIDX_W-1:0] exp_idx;

        start = 1'b1; iter_count = ITER_W'(iter); cfg_valid = 1'b0;
        step();
        if (!hold_start) start = 1'b0;
        iter_count = ITER_W'($urandom);
        nh = 0; last_hs = -1000; pend = 1'b0; wr_idx = 0; wr_word = '0; t = 1;
        while (1) begin
            exp_en = '0;
            if (pend) exp_en[wr_idx] = 1'b1;
            rdy     = (t >= 2) && (nh < NUM_PE);
            op      = (nh == NUM_PE) && (t >= last_hs + 2) && (t <= last_hs + 1 + iter);
            dn      = (nh == NUM_PE) && (t == last_hs + 2 + iter);
            bz      = !((nh == NUM_PE) && (t > last_hs + 2 + iter));
            exp_idx = PIDX_W'(nh % NUM_PE);
            tests++; if (pe_clear !== (t == 1)) begin fails++; $display("FAIL %s pe_clear t=%0d got %b exp %b", name, t, pe_clear, (t == 1)); end
            tests++; if (instr_en !== exp_en)   begin fails++; $display("FAIL %s instr_en t=%0d got %b exp %b", name, t, instr_en, exp_en); end
            tests++; if (instr_data !== exp_data) begin fails++; $display("FAIL %s instr_data t=%0d got %h exp %h", name, t, instr_data, exp_data); end
            tests++; if (cfg_ready !== rdy)     begin fails++; $display("FAIL %s cfg_ready t=%0d got %b exp %b", name, t, cfg_ready, rdy); end
            tests++; if (operand_en !== op)     begin fails++; $display("FAIL %s operand_en t=%0d got %b exp %b", name, t, operand_en, op); end
            tests++; if (done !== dn)           begin fails++; $display("FAIL %s done t=%0d got %b exp %b", name, t, done, dn); end
            tests++; if (busy !== bz)           begin fails++; $display("FAIL %s busy t=%0d got %b exp %b", name, t, busy, bz); end
            tests++; if (pe_idx !== exp_idx)    begin fails++; $display("FAIL %s pe_idx t=%0d got %0d exp %0d", name, t, pe_idx, exp_idx); end
            if (!bz) break;
            if (t > 400) begin
                fails++;
                $display("FAIL %s timeout t=%0d busy still %b", name, t, busy);
                break;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = t[0];
                default: v = ($urandom_range(99) < 50);
            endcase
            w = $urandom;
            cfg_valid = v; cfg_word = w;
            pend = v && rdy;
            if (pend) begin
                wr_idx = nh; wr_word = w; nh++;
                if (nh == NUM_PE) last_hs = t;
            end
            step();
            t++;
            if (pend) exp_data = wr_word;
        end
        cfg_valid = 1'b0;
        if (hold_start) begin
            step();
            tests++; if (pe_clear !== 1'b1) begin fails++; $display("FAIL %s restart pe_clear got %b exp 1", name, pe_clear); end
            tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL %s restart busy got %b exp 1", name, busy); end
            start = 1'b0; abort = 1'b1;
            step();
            abort = 1'b0;
            tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL %s restart abort busy got %b exp 0", name, busy); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] w0;
        logic [31:0] w1;
        start = 1'b1; abort = 1'b1; iter_count = 16'd5;
        step();
        abort = 1'b0; start = 1'b0;
        tests++; if (pe_clear !== 0 || busy !== 0) begin fails++; $display("FAIL abort_vs_start got clear=%b busy=%b exp 0 0", pe_clear, busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        w0 = $urandom; w1 = $urandom;
        cfg_valid = 1'b1; cfg_word = w0;
        step();
        step();
        cfg_word = w1;
        tests++; if (instr_en !== 4'b0001 || instr_data !== w0) begin fails++; $display("FAIL abort word0 got %b/%h exp 0001/%h", instr_en, instr_data, w0); end
        step();
        exp_data = w1;
        tests++; if (instr_en !== 4'b0010 || pe_idx !== 2) begin fails++; $display("FAIL abort word1 got %b idx %0d exp 0010 idx 2", instr_en, pe_idx); end
        abort = 1'b1;
        #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL abort cfg_ready got %b exp 0", cfg_ready); end
        step();
        abort = 1'b0; cfg_valid = 1'b0;
        tests++; if (instr_en !== '0)     begin fails++; $display("FAIL abort instr_en got %b exp 0", instr_en); end
        tests++; if (instr_data !== w1)   begin fails++; $display("FAIL abort instr_data got %h exp %h", instr_data, w1); end
        tests++; if (operand_en !== 0 || pe_clear !== 0) begin fails++; $display("FAIL abort strobes got op=%b clr=%b exp 0 0", operand_en, pe_clear); end
        tests++; if (busy !== 0)          begin fails++; $display("FAIL abort busy got %b exp 0", busy); end
        tests++; if (pe_idx !== '0)       begin fails++; $display("FAIL abort pe_idx got %0d exp 0", pe_idx); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (done !== 0) begin fails++; $display("FAIL abort no_done cycle %0d got %b exp 0", i, done); end
            step();
        end
    endtask

    task automatic test_reset_exec();
        start = 1'b1; iter_count = 16'd10;
        step();
        start = 1'b0; cfg_valid = 1'b1; cfg_word = $urandom;
        repeat (5) step();
        cfg_valid = 1'b0;
        repeat (2) step();
        tests++; if (operand_en !== 1'b1) begin fails++; $display("FAIL rst_exec pre operand_en got %b exp 1", operand_en); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_data = 32'h0;
        tests++; if (operand_en !== 0)  begin fails++; $display("FAIL rst_exec operand_en got %b exp 0", operand_en); end
        tests++; if (busy !== 0 || done !== 0 || pe_clear !== 0) begin fails++; $display("FAIL rst_exec flags got busy=%b done=%b clr=%b exp 0", busy, done, pe_clear); end
        tests++; if (instr_en !== '0 || instr_data !== '0 || pe_idx !== '0) begin fails++; $display("FAIL rst_exec bus got %b %h %0d exp 0", instr_en, instr_data, pe_idx); end
        step();
        tests++; if (operand_en !== 0)  begin fails++; $display("FAIL rst_exec after operand_en got %b exp 0", operand_en); end
    endtask

    initial begin
        test_reset();
        test_sequence("basic", 3, 0, 1'b0);
        test_sequence("backpressure", 3, 1, 1'b0);
        test_sequence("zero_iter", 0, 0, 1'b0);
        test_abort();
        test_sequence("after_abort", 2, 0, 1'b0);
        test_sequence("back_to_back", 2, 2, 1'b1);
        for (int i = 0; i < 6; i++) test_sequence("random", $urandom_range(0, 6), 2, 1'b0);
        test_reset_exec();
        test_sequence("after_reset", 1, 2, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
